// File: rtl/dispatch_pkg.sv
// Shared decode constants and the dispatch uop bundle.
package dispatch_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_TAG_W = 6;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        INST_NONE       = 3'd0,
        INST_INTEGER    = 3'd1,
        INST_BRANCH     = 3'd2,
        INST_LOAD_STORE = 3'd3,
        INST_ILLEGAL    = 3'd7
    } inst_type_e;

    localparam int RS_INT = 2;
    localparam int RS_BR  = 1;
    localparam int RS_LS  = 0;

    typedef struct packed {
        logic [3:0]           op;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic                 v1;
        logic [XLEN-1:0]      op1;
        logic                 v2;
        logic [XLEN-1:0]      op2;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      offset;
    } uop_t;

endpackage

// File: rtl/dispatch_decode.sv
// Combinational decode of the buffer head into station target and uop fields.
module dispatch_decode
    import dispatch_pkg::*;
(
    input  logic [31:0]     inst,
    output logic [2:0]      tgt,
    output logic [3:0]      op,
    output logic [4:0]      src_reg1,
    output logic [4:0]      src_reg2,
    output logic            use1,
    output logic            use2,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] offset,
    output logic            use_pc,
    output logic [4:0]      arf_dest,
    output inst_type_e      inst_type,
    output logic            legal
);

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] i_imm, s_imm, b_imm, j_imm, u_imm;

    assign opc = inst[6:0];
    assign rd  = inst[11:7];
    assign f3  = inst[14:12];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];

    assign i_imm = XLEN'($signed(inst[31:20]));
    assign s_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign b_imm = XLEN'($signed({inst[31], inst[7], inst[30:25],
                                  inst[11:8], 1'b0}));
    assign j_imm = XLEN'($signed({inst[31], inst[19:12], inst[20],
                                  inst[30:21], 1'b0}));
    assign u_imm = XLEN'($signed({inst[31:12], 12'b0}));

    always_comb begin
        tgt       = '0;
        op        = '0;
        src_reg1  = '0;
        src_reg2  = '0;
        use1      = 1'b0;
        use2      = 1'b0;
        imm       = '0;
        offset    = '0;
        use_pc    = 1'b0;
        arf_dest  = '0;
        inst_type = INST_ILLEGAL;
        legal     = 1'b1;
        unique case (1'b1)
            opc == OPC_OP: begin
                tgt[RS_INT] = 1'b1;
                op          = {f3, inst[30]};
                src_reg1    = rs1;
                src_reg2    = rs2;
                use1        = 1'b1;
                use2        = 1'b1;
                arf_dest    = rd;
                inst_type   = INST_INTEGER;
            end
            opc == OPC_OP_IMM: begin
                tgt[RS_INT] = 1'b1;
                op          = {f3, 1'b0};
                src_reg1    = rs1;
                use1        = 1'b1;
                imm         = i_imm;
                arf_dest    = rd;
                inst_type   = INST_INTEGER;
            end
            opc == OPC_LUI: begin
                tgt[RS_INT] = 1'b1;
                imm         = u_imm;
                arf_dest    = rd;
                inst_type   = INST_INTEGER;
            end
            opc == OPC_BRANCH: begin
                tgt[RS_BR] = 1'b1;
                op         = {1'b1, f3};
                src_reg1   = rs1;
                src_reg2   = rs2;
                use1       = 1'b1;
                use2       = 1'b1;
                offset     = b_imm;
                use_pc     = 1'b1;
                inst_type  = INST_BRANCH;
            end
            opc == OPC_JAL: begin
                tgt[RS_BR] = 1'b1;
                offset     = j_imm;
                use_pc     = 1'b1;
                arf_dest   = rd;
                inst_type  = INST_BRANCH;
            end
            opc == OPC_JALR: begin
                tgt[RS_BR] = 1'b1;
                op         = 4'b1100;
                src_reg1   = rs1;
                use1       = 1'b1;
                offset     = i_imm;
                use_pc     = 1'b1;
                arf_dest   = rd;
                inst_type  = INST_BRANCH;
            end
            opc == OPC_LOAD: begin
                tgt[RS_LS] = 1'b1;
                op         = {1'b0, f3};
                src_reg1   = rs1;
                use1       = 1'b1;
                offset     = i_imm;
                arf_dest   = rd;
                inst_type  = INST_LOAD_STORE;
            end
            opc == OPC_STORE: begin
                tgt[RS_LS] = 1'b1;
                op         = {1'b1, f3};
                src_reg1   = rs1;
                src_reg2   = rs2;
                use1       = 1'b1;
                use2       = 1'b1;
                offset     = s_imm;
                inst_type  = INST_LOAD_STORE;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/dispatch_queue.sv
// Fetch buffer with head decode and one-per-cycle RS/ROB dispatch.
// DISPATCH_ILLEGAL_TRAP_EN: forward unknown opcodes to the ROB as INST_ILLEGAL.
module dispatch_queue #(
    parameter int XLEN      = 32,
    parameter int ROB_TAG_W = 6,
    parameter int DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  fetch_valid,
    output logic                  fetch_ready,
    input  logic [XLEN-1:0]       fetch_pc,
    input  logic [31:0]           fetch_inst,
    input  logic                  fetch_pred_taken,
    output logic [4:0]            src_reg1,
    output logic [4:0]            src_reg2,
    input  logic [XLEN:0]         src_data1,
    input  logic [XLEN:0]         src_data2,
    output logic [2:0]            rs_valid,
    input  logic [2:0]            rs_ready,
    output dispatch_pkg::uop_t    rs_uop,
    output logic                  rob_alloc_valid,
    input  logic                  rob_alloc_ready,
    input  logic [ROB_TAG_W-1:0]  rob_free_tag,
    output logic [3+XLEN+5+1-1:0] rob_data,
    output logic                  dp_stall
);
    import dispatch_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [31:0]     inst_q [DEPTH];
    logic            pred_q [DEPTH];

    logic            head_valid, push, fire, live;
    logic            rs_ok, rob_ok, rob_req;
    logic [31:0]     dec_inst;
    logic [2:0]      d_tgt;
    logic [3:0]      d_op;
    logic            d_use1, d_use2, d_use_pc, d_legal;
    logic [XLEN-1:0] d_imm, d_offset;
    logic [4:0]      d_rd;
    inst_type_e      d_type;
    uop_t            uop;

    assign head_valid  = count != '0;
    assign fetch_ready = count < CW'(DEPTH);
    assign push        = fetch_valid && fetch_ready && !flush;
    assign dec_inst    = head_valid ? inst_q[rd_ptr] : '0;

    dispatch_decode u_dec (
        .inst      (dec_inst),
        .tgt       (d_tgt),
        .op        (d_op),
        .src_reg1  (src_reg1),
        .src_reg2  (src_reg2),
        .use1      (d_use1),
        .use2      (d_use2),
        .imm       (d_imm),
        .offset    (d_offset),
        .use_pc    (d_use_pc),
        .arf_dest  (d_rd),
        .inst_type (d_type),
        .legal     (d_legal)
    );

    // Unknown opcodes have no station, so the RS side is treated as ready.
    assign rs_ok = d_legal ? |(d_tgt & rs_ready) : 1'b1;
`ifdef DISPATCH_ILLEGAL_TRAP_EN
    assign rob_ok  = rob_alloc_ready;
    assign rob_req = 1'b1;
`else
    assign rob_ok  = d_legal ? rob_alloc_ready : 1'b1;
    assign rob_req = d_legal;
`endif

    assign live            = head_valid && !flush;
    assign fire            = live && rs_ok && rob_ok;
    assign rs_valid        = d_tgt & {3{live && rob_ok}};
    assign rob_alloc_valid = live && rob_req && rs_ok;
    assign dp_stall        = live && !fire;

    always_comb begin
        uop = '0;
        if (head_valid) begin
            uop.op      = d_op;
            uop.rob_tag = rob_free_tag;
            uop.v1      = d_use1 ? src_data1[XLEN] : 1'b1;
            uop.op1     = d_use1 ? src_data1[XLEN-1:0] : '0;
            uop.v2      = d_use2 ? src_data2[XLEN] : 1'b1;
            uop.op2     = d_use2 ? src_data2[XLEN-1:0] : d_imm;
            uop.pc      = d_use_pc ? pc_q[rd_ptr] : '0;
            uop.offset  = d_offset;
        end
    end

    assign rs_uop   = uop;
    assign rob_data = head_valid ?
                      {d_type, pc_q[rd_ptr], d_rd, pred_q[rd_ptr]} : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (fire) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(fire);
        end
    end

    // Payload needs no reset; count gates every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]   <= fetch_pc;
            inst_q[wr_ptr] <= fetch_inst;
            pred_q[wr_ptr] <= fetch_pred_taken;
        end
    end

endmodule
